switch_merge: RTL

Two-to-one merge unit, the return path of the address-split switch. It accepts independent address/data streams on port A (low address range) and port B (high address range) and buffers each in a small FIFO. It arbitrates round-robin onto a single registered output stream with valid/ready backpressure. It sits downstream of the two split targets and recombines their traffic toward a single consumer.

---
 rtl/switch_pkg.sv | 13 +
 rtl/merge_fifo.sv | 39 +++
 rtl/switch_merge.sv | 63 ++++++
 3 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared types for the address-split switch return path
package switch_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;
   function automatic src_t other(input src_t s);
      return (s == SRC_A) ? SRC_B : SRC_A;
   endfunction
endpackage

// File: rtl/merge_fifo.sv
// merge_fifo: synchronous FIFO with count-based full/empty and free-running wrap pointers
module merge_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign head    = mem[rp];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/switch_merge.sv
// switch_merge: two-port FIFO-buffered round-robin merge onto one registered output stream
module switch_merge
   import switch_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  vld_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic                  rdy_a,
   input  logic                  vld_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic                  rdy_b,
   output logic                  vld,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  src,
   input  logic                  rdy
);
   localparam int W  = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH+1);
   logic [W-1:0] head_a, head_b;
   logic [CW-1:0] count_a, count_b;
   logic full_a, full_b, empty_a, empty_b;
   logic free, grant_a, grant_b;
   src_t prio;
   merge_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk(clk), .rstn(rstn), .push(vld_a && rdy_a), .din({addr_a, data_a}), .pop(grant_a),
      .head(head_a), .count(count_a), .full(full_a), .empty(empty_a)
   );
   merge_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk(clk), .rstn(rstn), .push(vld_b && rdy_b), .din({addr_b, data_b}), .pop(grant_b),
      .head(head_b), .count(count_b), .full(full_b), .empty(empty_b)
   );
   // ready tracks registered fullness only, so a full FIFO stalls a cycle even while draining
   assign rdy_a   = rstn && !full_a;
   assign rdy_b   = rstn && !full_b;
   assign free    = !vld || rdy;
   assign grant_a = free && !empty_a && (empty_b || prio == SRC_A);
   assign grant_b = free && !empty_b && (empty_a || prio == SRC_B);
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld  <= 1'b0;
         addr <= '0;
         data <= '0;
         src  <= SRC_A;
         prio <= SRC_A;
      end else if (free) begin
         vld <= grant_a || grant_b;
         if (grant_a || grant_b) begin
            {addr, data} <= grant_a ? head_a : head_b;
            src          <= grant_a ? SRC_A : SRC_B;
            prio         <= other(grant_a ? SRC_A : SRC_B);
         end
      end
   end
   a_count_bound: assert property (@(posedge clk) count_a <= CW'(FIFO_DEPTH) && count_b <= CW'(FIFO_DEPTH));
endmodule
